// File: rtl/mic1_pkg.sv
// mic1_pkg: shared MIC-1 datapath constants, B-bus select codes, C-bus enable indices and shifter control
package mic1_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;
    localparam int C_N   = 9;
    typedef enum logic [3:0] {
        B_MDR, B_PC, B_MBR, B_MBRU, B_SP, B_LV, B_CPP, B_TOS, B_OPC
    } bsel_t;
    typedef enum logic [1:0] {SH_NONE, SH_SLL8, SH_SRA1, SH_RSVD} shift_t;
endpackage

// File: rtl/mem_request_tracker.sv
// mem_request_tracker: one-cycle memory request strobes and MDR/MBR capture enables
module mem_request_tracker (
    input  logic clk,
    input  logic reset,
    input  logic rd,
    input  logic wr,
    input  logic fetch,
    output logic memRead,
    output logic memWrite,
    output logic memFetch,
    output logic captureMdr,
    output logic captureMbr
);
    logic rdPending, wrPending, fetchPending;
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPending    <= 1'b0;
            wrPending    <= 1'b0;
            fetchPending <= 1'b0;
        end else begin
            rdPending    <= rd & ~wr;
            wrPending    <= wr;
            fetchPending <= fetch;
        end
    end
    assign memRead    = rdPending;
    assign memWrite   = wrPending;
    assign memFetch   = fetchPending;
    // a reset edge swallows any capture that would otherwise end this strobe cycle
    assign captureMdr = rdPending & ~reset;
    assign captureMbr = fetchPending & ~reset;
endmodule

// File: rtl/register_bank.sv
// register_bank: MIC-1 C-bus register file, A/B bus sources and memory port sequencing
module register_bank
    import mic1_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] cBus,
    input  logic [C_N-1:0]    cEnable,
    input  logic [3:0]        bSelect,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    input  logic [WORD_W-1:0] memReadData,
    input  logic [BYTE_W-1:0] fetchData,
    output logic [WORD_W-1:0] aBus,
    output logic [WORD_W-1:0] bBus,
    output logic [WORD_W-1:0] memAddr,
    output logic [WORD_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    output logic [WORD_W-1:0] fetchAddr,
    output logic              memFetch
);
    logic [WORD_W-1:0] regs [C_N];
    logic [BYTE_W-1:0] mbr;
    logic captureMdr, captureMbr;
    mem_request_tracker u_trk (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
        .memRead(memRead), .memWrite(memWrite), .memFetch(memFetch),
        .captureMdr(captureMdr), .captureMbr(captureMbr)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_N; i++) regs[i] <= '0;
            mbr <= '0;
        end else begin
            for (int i = 0; i < C_N; i++) if (cEnable[i]) regs[i] <= cBus;
            // memory capture is written last so it beats a same-edge C-bus write to MDR
            if (captureMdr) regs[C_MDR] <= memReadData;
            if (captureMbr) mbr <= fetchData;
        end
    end
    always_comb begin
        bBus = '0;
        case (bSelect)
            B_MDR:   bBus = regs[C_MDR];
            B_PC:    bBus = regs[C_PC];
            B_MBR:   bBus = {{(WORD_W-BYTE_W){mbr[BYTE_W-1]}}, mbr};
            B_MBRU:  bBus = {{(WORD_W-BYTE_W){1'b0}}, mbr};
            B_SP:    bBus = regs[C_SP];
            B_LV:    bBus = regs[C_LV];
            B_CPP:   bBus = regs[C_CPP];
            B_TOS:   bBus = regs[C_TOS];
            B_OPC:   bBus = regs[C_OPC];
            default: bBus = '0;
        endcase
    end
    assign aBus         = regs[C_H];
    assign memAddr      = regs[C_MAR];
    assign memWriteData = regs[C_MDR];
    assign fetchAddr    = regs[C_PC];
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed vector table, hand sequences and randomized model check for register_bank
module tb_register_bank;
    logic        clk = 0;
    logic        reset;
    logic [31:0] cBus;
    logic [8:0]  cEnable;
    logic [3:0]  bSelect;
    logic        rd, wr, fetch;
    logic [31:0] memReadData;
    logic [7:0]  fetchData;
    logic [31:0] aBus, bBus, memAddr, memWriteData, fetchAddr;
    logic        memRead, memWrite, memFetch;
    int total = 0;
    int bad = 0;

    register_bank dut (
        .clk(clk), .reset(reset), .cBus(cBus), .cEnable(cEnable), .bSelect(bSelect),
        .rd(rd), .wr(wr), .fetch(fetch), .memReadData(memReadData), .fetchData(fetchData),
        .aBus(aBus), .bBus(bBus), .memAddr(memAddr), .memWriteData(memWriteData),
        .memRead(memRead), .memWrite(memWrite), .fetchAddr(fetchAddr), .memFetch(memFetch)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [31:0] cbus;
        logic [8:0]  cen;
        bit          rd, wr, fe;
        logic [31:0] mrd;
        logic [7:0]  fdat;
        logic [3:0]  bsel;
        logic [31:0] e_b, e_a, e_addr;
        bit          e_rd, e_wr, e_fe;
    } vec_t;
    vec_t tv[$];

    // reference model: register contents by name, MBR byte, and the strobes visible this cycle
    logic [31:0] m_mar, m_mdr, m_pc, m_sp, m_lv, m_cpp, m_tos, m_opc, m_h;
    logic [7:0]  m_mbr;
    bit          s_rd, s_wr, s_fe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_bbus(input int s);
        case (s)
            0: return m_mdr;
            1: return m_pc;
            2: return 32'($signed(m_mbr));
            3: return 32'(m_mbr);
            4: return m_sp;
            5: return m_lv;
            6: return m_cpp;
            7: return m_tos;
            8: return m_opc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_edge();
        if (reset) begin
            {m_mar, m_mdr, m_pc, m_sp, m_lv, m_cpp, m_tos, m_opc, m_h} = '0;
            m_mbr = 0;
            {s_rd, s_wr, s_fe} = 3'b0;
        end else begin
            if (cEnable[0]) m_mar = cBus;
            if (cEnable[1]) m_mdr = cBus;
            if (cEnable[2]) m_pc  = cBus;
            if (cEnable[3]) m_sp  = cBus;
            if (cEnable[4]) m_lv  = cBus;
            if (cEnable[5]) m_cpp = cBus;
            if (cEnable[6]) m_tos = cBus;
            if (cEnable[7]) m_opc = cBus;
            if (cEnable[8]) m_h   = cBus;
            if (s_rd) m_mdr = memReadData;
            if (s_fe) m_mbr = fetchData;
            s_rd = rd && !wr;
            s_wr = wr;
            s_fe = fetch;
        end
    endtask

    task automatic idle();
        cBus = 0; cEnable = 0; rd = 0; wr = 0; fetch = 0; memReadData = 0; fetchData = 0;
    endtask

    task automatic add(input logic [31:0] cb, input logic [8:0] ce, input bit r, input bit w, input bit f,
                       input logic [31:0] mr, input logic [7:0] fd, input logic [3:0] bs,
                       input logic [31:0] eb, input logic [31:0] ea, input logic [31:0] ead,
                       input bit erd, input bit ewr, input bit efe);
        vec_t v;
        v = '{cb, ce, r, w, f, mr, fd, bs, eb, ea, ead, erd, ewr, efe};
        tv.push_back(v);
    endtask

    localparam logic [31:0] K = 32'h1234_5678;

    initial begin
        idle();
        reset = 1; bSelect = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst memRead", 32'(memRead), 0);
        chk("rst memWrite", 32'(memWrite), 0);
        chk("rst memFetch", 32'(memFetch), 0);
        chk("rst aBus", aBus, 0);
        chk("rst memAddr", memAddr, 0);
        chk("rst fetchAddr", fetchAddr, 0);
        for (int s = 0; s < 16; s++) begin
            bSelect = 4'(s); #1;
            chk($sformatf("rst bBus sel%0d", s), bBus, 0);
        end
        reset = 0;

        add(K, 9'h1FF, 0,0,0, 0, 0, 0, K, K, K, 0,0,0);
        add(0, 0, 0,0,0, 0, 0, 1, K, K, K, 0,0,0);
        for (int s = 4; s <= 8; s++) add(0, 0, 0,0,0, 0, 0, 4'(s), K, K, K, 0,0,0);
        add(0, 0, 0,0,0, 0, 0, 2, 0, K, K, 0,0,0);
        add(0, 0, 0,0,0, 0, 0, 3, 0, K, K, 0,0,0);
        add(0, 0, 0,0,0, 0, 0, 9, 0, K, K, 0,0,0);
        add(32'h40, 9'h001, 1,0,0, 0, 0, 9, 0, K, 32'h40, 1,0,0);
        add(0, 0, 0,0,0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, K, 32'h40, 0,0,0);
        add(32'h10, 9'h004, 0,0,1, 0, 0, 3, 0, K, 32'h40, 0,0,1);
        add(0, 0, 0,0,0, 0, 8'hF0, 2, 32'hFFFF_FFF0, K, 32'h40, 0,0,0);
        add(0, 0, 0,0,0, 0, 8'h55, 3, 32'h0000_00F0, K, 32'h40, 0,0,0);
        add(32'hCAFE_0001, 9'h002, 0,0,0, 0, 0, 0, 32'hCAFE_0001, K, 32'h40, 0,0,0);
        add(0, 0, 1,1,0, 0, 0, 0, 32'hCAFE_0001, K, 32'h40, 0,1,0);
        add(0, 0, 0,0,0, 32'h9999_9999, 0, 0, 32'hCAFE_0001, K, 32'h40, 0,0,0);
        add(0, 0, 1,0,0, 0, 0, 0, 32'hCAFE_0001, K, 32'h40, 1,0,0);
        add(32'h1111_1111, 9'h002, 0,0,0, 32'h2222_2222, 0, 0, 32'h2222_2222, K, 32'h40, 0,0,0);

        foreach (tv[i]) begin
            cBus = tv[i].cbus; cEnable = tv[i].cen; rd = tv[i].rd; wr = tv[i].wr; fetch = tv[i].fe;
            memReadData = tv[i].mrd; fetchData = tv[i].fdat; bSelect = tv[i].bsel;
            @(posedge clk); #1;
            chk($sformatf("vec%0d bBus", i), bBus, tv[i].e_b);
            chk($sformatf("vec%0d aBus", i), aBus, tv[i].e_a);
            chk($sformatf("vec%0d memAddr", i), memAddr, tv[i].e_addr);
            chk($sformatf("vec%0d memRead", i), 32'(memRead), 32'(tv[i].e_rd));
            chk($sformatf("vec%0d memWrite", i), 32'(memWrite), 32'(tv[i].e_wr));
            chk($sformatf("vec%0d memFetch", i), 32'(memFetch), 32'(tv[i].e_fe));
            if (tv[i].bsel == 0) chk($sformatf("vec%0d memWriteData", i), memWriteData, tv[i].e_b);
        end

        // read issued, then reset lands while the strobe is up
        idle(); rd = 1; bSelect = 9;
        @(posedge clk); #1;
        chk("seq6 memRead up", 32'(memRead), 1);
        chk("seq6 sel9", bBus, 0);
        idle(); reset = 1; memReadData = 32'hABCD_ABCD;
        @(posedge clk); #1;
        chk("seq6 memRead after reset", 32'(memRead), 0);
        chk("seq6 sel9 in reset", bBus, 0);
        bSelect = 0; #1;
        chk("seq6 MDR after reset", bBus, 0);
        rd = 1; fetch = 1;
        @(posedge clk); #1;
        reset = 0; rd = 0; fetch = 0;
        chk("seq6 rd during reset", 32'(memRead), 0);
        chk("seq6 fetch during reset", 32'(memFetch), 0);
        @(posedge clk); #1;
        chk("seq6 no late strobe", 32'(memRead), 0);

        reset = 1; idle();
        @(posedge clk); m_edge(); #1;
        reset = 0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            cBus = $urandom;
            cEnable = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(0, 9));
            rd = $urandom_range(0, 2) == 0;
            wr = $urandom_range(0, 3) == 0;
            fetch = $urandom_range(0, 2) == 0;
            memReadData = $urandom;
            fetchData = 8'($urandom);
            @(posedge clk); m_edge(); #1;
            chk("rnd memRead", 32'(memRead), 32'(s_rd));
            chk("rnd memWrite", 32'(memWrite), 32'(s_wr));
            chk("rnd memFetch", 32'(memFetch), 32'(s_fe));
            chk("rnd aBus", aBus, m_h);
            chk("rnd memAddr", memAddr, m_mar);
            chk("rnd memWriteData", memWriteData, m_mdr);
            chk("rnd fetchAddr", fetchAddr, m_pc);
            for (int s = 0; s < 16; s++) begin
                bSelect = 4'(s); #1;
                chk($sformatf("rnd bBus sel%0d", s), bBus, m_bbus(s));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_bank.md
# register_bank

MIC-1 datapath register bank: the receiving end of the shifter's C-bus output and the source of the A and B buses that feed the ALU. It latches the shifter result into any subset of the nine C-writable registers and drives the selected register onto the B bus, with MBR sign- or zero-extended. It also sequences the one-cycle-latency memory read, write and fetch ports so that MDR and MBR are reloaded from memory exactly as the microcode expects.

## Interface
- No parameters; data width fixed at 32, MBR width 8.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cBus  in  32  shifter dataOut
- cEnable  in  9  one-hot-or-multi write enables: bit0 MAR, 1 MDR, 2 PC, 3 SP, 4 LV, 5 CPP, 6 TOS, 7 OPC, 8 H
- bSelect  in  4  B-bus source: 0 MDR, 1 PC, 2 MBR (sign-ext), 3 MBRU (zero-ext), 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9–15 drive 0
- rd, wr, fetch  in  1 each  memory requests from the current microinstruction
- memReadData  in  32  data word, valid in the cycle memRead is high
- fetchData  in  8  instruction byte, valid in the cycle memFetch is high
- aBus  out  32  always H
- bBus  out  32  per bSelect, combinational
- memAddr  out  32  MAR (word address)
- memWriteData  out  32  MDR
- memRead, memWrite  out  1  registered request strobes
- fetchAddr  out  32  PC (byte address)
- memFetch  out  1  registered fetch strobe

## Operation
- At each rising edge, every register whose cEnable bit is set loads cBus. Registers whose bit is clear hold their value.
- Requests are sampled at the same edge as C-bus writes. They set rdPending, wrPending and fetchPending, which are driven directly as memRead, memWrite and memFetch during the following cycle.
- memAddr, memWriteData and fetchAddr show the register values *after* that edge. "MAR=SP; rd" therefore addresses the new MAR.
- At the edge ending a memRead cycle, MDR loads memReadData. At the edge ending a memFetch cycle, MBR loads fetchData.
- MDR conflict: a C-bus write to MDR and a memory capture at the same edge are resolved in favour of the memory capture.
- rd and wr asserted in the same cycle: the write is performed and the read is dropped.
- fetch is independent of rd and wr, and any combination with them is legal.
- Back-to-back requests are legal. A new request overwrites the pending flag for the next cycle.
- MBR has no C-bus path. It changes only by fetch or reset.

## Timing
- Reset value of every register and of every pending flag/strobe is 0. aBus, bBus, memAddr, memWriteData and fetchAddr therefore read 0 after reset.
- bBus and aBus have zero latency from the register state and bSelect.
- Read latency: rd in cycle k → memRead high in cycle k+1 → MDR valid on bBus in cycle k+2. Fetch has the same latency to MBR.
- Write: wr in cycle k → memWrite high in cycle k+1 with the MDR/MAR values as they stand at the start of k+1.
- Reset asserted while a request is pending: pending flags clear at that edge, no capture occurs, and the strobe does not appear.
- MBR sign extension uses {{24{MBR[7]}}, MBR}. MBRU uses {24'b0, MBR}.

## Structure
- Shared package mic1_pkg holds:
  - bSelect codes (B_MDR … B_OPC)
  - cEnable bit indices (C_MAR … C_H)
  - width constants WORD_W = 32 and BYTE_W = 8
- The shifter control encoding also lives in mic1_pkg, so microcode decode can import a single package.
- Sub-module mem_request_tracker:
  - owns the three pending flags, the rd/wr priority and reset clearing
  - outputs the strobes and the captureMdr/captureMbr enables
- register_bank instantiates mem_request_tracker and implements the register array and the B-bus mux.

## Test plan
1. Reset, then cBus=32'h1234_5678 with cEnable=9'h1FF for one cycle → every bSelect 0,1,4–8 reads 32'h1234_5678, aBus=32'h1234_5678, MBR still 0.
2. cBus=32'h0000_0040 with cEnable[MAR] and rd in the same cycle → next cycle memRead=1 and memAddr=32'h40. Drive memReadData=32'hDEAD_BEEF → cycle after, bSelect=0 reads 32'hDEAD_BEEF.
3. fetch with PC=32'h10, fetchData=8'hF0 → two cycles later bSelect=2 reads 32'hFFFF_FFF0 and bSelect=3 reads 32'h0000_00F0.
4. rd and wr together with MDR=32'hCAFE_0001 → next cycle memWrite=1, memRead=0, memWriteData=32'hCAFE_0001, and MDR is not reloaded.
5. C-bus write to MDR (32'h1111_1111) at the same edge as memory capture (32'h2222_2222) → MDR=32'h2222_2222.
6. Issue rd, then assert reset in the following cycle → memRead low after the reset edge, MDR=0; bSelect=9 reads 0 at all times.
